totp_truncate: RTL and testbench

TOTP_TRUNCATE -- requirements
Module: totp_truncate

---
 rtl/totp_truncate.sv | 120 ++++++++++++
 tb/tb_totp_truncate.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/totp_truncate.sv
// Serial HMAC-SHA1 digest -> dynamic truncation -> DIGITS packed BCD digits, done 33 cycles after the 160th bit.
// No backpressure: bits offered while busy are dropped. Define TOTP_TRUNCATE_RAW_EN to add the 31-bit raw_out port.
module totp_truncate #(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic                  in_bit,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits
`ifdef TOTP_TRUNCATE_RAW_EN
  ,
  output logic [30:0]           raw_out
`endif
);

  typedef enum logic [1:0] {COLLECT, EXTRACT, CONVERT, DONE} state_t;

  state_t       state, state_nxt;
  logic [159:0] sr;
  logic [7:0]   bit_cnt;
  logic [4:0]   iter;
  logic [30:0]  p;
  logic [39:0]  acc;
  logic [39:0]  acc_adj;
  logic [7:0]   p_top;
  logic [30:0]  p_sel;
  logic         last_bit;
  logic         unused_nibble;

  assign last_bit = (state == COLLECT) && in_valid && (bit_cnt == 8'd159);

  // Byte 0 sits at sr[159:152]; P skips bit 31 of the window, so start one bit below it.
  assign p_top = 8'd158 - {1'b0, sr[3:0], 3'b000};
  assign p_sel = sr[p_top -: 31];
  // High nibble of byte 19 never feeds P or the offset.
  assign unused_nibble = ^sr[7:4];

  always_comb begin
    acc_adj = acc;
    for (int n = 0; n < 10; n++) begin
      if (acc[4*n +: 4] >= 4'd5) acc_adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (last_bit) state_nxt = EXTRACT;
        EXTRACT: state_nxt = CONVERT;
        CONVERT: if (iter == 5'd30) state_nxt = DONE;
        DONE:    state_nxt = COLLECT;
        default: state_nxt = COLLECT;
      endcase
    end
  end

  always_comb begin
    busy = (state != COLLECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      iter    <= '0;
      p       <= '0;
      acc     <= '0;
      done    <= 1'b0;
      digits  <= '0;
`ifdef TOTP_TRUNCATE_RAW_EN
      raw_out <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (clear) begin
        bit_cnt <= '0;
        iter    <= '0;
      end else begin
        case (state)
          COLLECT: begin
            if (in_valid) begin
              sr      <= {sr[158:0], in_bit};
              bit_cnt <= last_bit ? 8'd0 : bit_cnt + 8'd1;
            end
          end
          EXTRACT: begin
            p    <= p_sel;
            acc  <= '0;
            iter <= '0;
          end
          CONVERT: begin
            acc  <= {acc_adj[38:0], p[5'd30 - iter]};
            iter <= (iter == 5'd30) ? 5'd0 : iter + 5'd1;
          end
          DONE: begin
            digits  <= acc[4*DIGITS-1:0];
            done    <= 1'b1;
`ifdef TOTP_TRUNCATE_RAW_EN
            raw_out <= p;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_totp_truncate.sv
// Directed bench for totp_truncate: DIGITS=6 and DIGITS=8 instances share one input stream.
module tb_totp_truncate;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        busy6, done6, busy8, done8;
  logic [23:0] digits6;
  logic [31:0] digits8;
`ifdef TOTP_TRUNCATE_RAW_EN
  logic [30:0] raw6, raw8;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_done6 = 0;
  int n0;
  int lat;

  localparam logic [159:0] VEC_A = 160'hcc93cf18508d94934c64b65d8ba7667fb7cde4b0;
  localparam logic [159:0] VEC_B = 160'h1f8698690e02ca16618550ef7f19da8e945b555a;
  localparam logic [159:0] VEC_C = {120'h0, 40'hFFFFFFFF0F};

  totp_truncate #(.DIGITS(6)) dut6 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .busy(busy6), .done(done6), .digits(digits6)
`ifdef TOTP_TRUNCATE_RAW_EN
    , .raw_out(raw6)
`endif
  );

  totp_truncate #(.DIGITS(8)) dut8 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .busy(busy8), .done(done8), .digits(digits8)
`ifdef TOTP_TRUNCATE_RAW_EN
    , .raw_out(raw8)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done6) n_done6 <= n_done6 + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [159:0] d, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = d[159-i];
      step();
      if (gaps && i < n - 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) step();
      end
    end
    in_valid = 1'b0;
  endtask

  // Returns cycles from the last-bit edge to the edge raising done, or -1 on timeout.
  task automatic wait_done(input bit noisy, output int latency);
    int t0;
    t0 = cyc;
    latency = -1;
    for (int i = 0; i < 60; i++) begin
      in_valid = noisy;
      in_bit   = 1'($urandom_range(0, 1));
      step();
      if (done6) begin
        latency = cyc - t0;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [159:0] d, input bit gaps, input bit noisy,
                       input logic [23:0] e6, input logic [31:0] e8);
    int l;
    send_bits(d, 160, gaps);
    check({tag, "_busy"}, 64'(busy6), 64'd1);
    wait_done(noisy, l);
    check({tag, "_latency"}, 64'(l), 64'd33);
    check({tag, "_done8"}, 64'(done8), 64'd1);
    check({tag, "_digits6"}, 64'(digits6), 64'(e6));
    check({tag, "_digits8"}, 64'(digits8), 64'(e8));
  endtask

  initial begin
    repeat (3) step();
    check("rst_busy", 64'(busy6), 64'd0);
    check("rst_done", 64'(done6), 64'd0);
    check("rst_digits6", 64'(digits6), 64'd0);
    check("rst_digits8", 64'(digits8), 64'd0);
`ifdef TOTP_TRUNCATE_RAW_EN
    check("rst_raw", 64'(raw6), 64'd0);
`endif
    rst = 1'b0;
    step();

    frame("A", VEC_A, 1'b0, 1'b0, 24'h755224, 32'h84755224);
`ifdef TOTP_TRUNCATE_RAW_EN
    check("A_raw", 64'(raw6), 64'd1284755224);
    check("A_raw8", 64'(raw8), 64'd1284755224);
`endif
    step();
    check("A_single_pulse", 64'(done6), 64'd0);
    check("A_hold", 64'(digits6), 64'h755224);

    frame("B", VEC_B, 1'b0, 1'b0, 24'h872921, 32'h57872921);
    frame("C", VEC_C, 1'b0, 1'b0, 24'h483647, 32'h47483647);

    // Gapped input, bits offered while busy, then a back-to-back frame.
    frame("A_gaps", VEC_A, 1'b1, 1'b1, 24'h755224, 32'h84755224);
    frame("B_b2b", VEC_B, 1'b0, 1'b0, 24'h872921, 32'h57872921);

    step();
    n0 = n_done6;
    send_bits(VEC_A, 80, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    frame("B_after_clear", VEC_B, 1'b0, 1'b0, 24'h872921, 32'h57872921);
    step();
    check("clear80_done_count", 64'(n_done6 - n0), 64'd1);

    n0 = n_done6;
    send_bits(VEC_A, 159, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_bit = VEC_A[0];
    step();
    clear = 1'b0; in_valid = 1'b0;
    check("clear160_busy", 64'(busy6), 64'd0);
    repeat (40) step();
    check("clear160_no_done", 64'(n_done6 - n0), 64'd0);
    check("clear160_retain", 64'(digits6), 64'h872921);
    frame("C_after_clear160", VEC_C, 1'b0, 1'b0, 24'h483647, 32'h47483647);

    step();
    n0 = n_done6;
    send_bits(VEC_B, 160, 1'b0);
    repeat (5) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clearconv_busy", 64'(busy6), 64'd0);
    repeat (40) step();
    check("clearconv_no_done", 64'(n_done6 - n0), 64'd0);
    check("clearconv_retain", 64'(digits8), 64'h47483647);

    send_bits(VEC_A, 160, 1'b0);
    repeat (10) step();
    #2 rst = 1'b1;
    #1;
    check("rstconv_busy", 64'(busy6), 64'd0);
    check("rstconv_done", 64'(done6), 64'd0);
    check("rstconv_digits6", 64'(digits6), 64'd0);
    check("rstconv_digits8", 64'(digits8), 64'd0);
`ifdef TOTP_TRUNCATE_RAW_EN
    check("rstconv_raw", 64'(raw6), 64'd0);
`endif
    step();
    rst = 1'b0;
    n0 = n_done6;
    repeat (40) step();
    check("rstconv_no_done", 64'(n_done6 - n0), 64'd0);
    frame("A_after_rst", VEC_A, 1'b0, 1'b0, 24'h755224, 32'h84755224);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
